// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg : shared states, ALU/condition codes and output decode for the
//            multicycle controller.                              Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    LINK   = 4'd9,
    BRANCH = 4'd10,
    UNDEF  = 4'd11
  } state_t;

  localparam logic [2:0] c_ALU_ADD = 3'd0;
  localparam logic [2:0] c_ALU_SUB = 3'd1;
  localparam logic [2:0] c_ALU_AND = 3'd2;
  localparam logic [2:0] c_ALU_ORR = 3'd3;
  localparam logic [2:0] c_ALU_EOR = 3'd4;
  localparam logic [2:0] c_ALU_MOV = 3'd5;

  localparam logic [3:0] c_CMD_AND = 4'b0000;
  localparam logic [3:0] c_CMD_EOR = 4'b0001;
  localparam logic [3:0] c_CMD_SUB = 4'b0010;
  localparam logic [3:0] c_CMD_ADD = 4'b0100;
  localparam logic [3:0] c_CMD_CMP = 4'b1010;
  localparam logic [3:0] c_CMD_ORR = 4'b1100;
  localparam logic [3:0] c_CMD_MOV = 4'b1101;

  localparam logic [3:0] c_COND_EQ = 4'b0000;
  localparam logic [3:0] c_COND_NE = 4'b0001;
  localparam logic [3:0] c_COND_CS = 4'b0010;
  localparam logic [3:0] c_COND_CC = 4'b0011;
  localparam logic [3:0] c_COND_MI = 4'b0100;
  localparam logic [3:0] c_COND_PL = 4'b0101;
  localparam logic [3:0] c_COND_VS = 4'b0110;
  localparam logic [3:0] c_COND_VC = 4'b0111;
  localparam logic [3:0] c_COND_HI = 4'b1000;
  localparam logic [3:0] c_COND_LS = 4'b1001;
  localparam logic [3:0] c_COND_GE = 4'b1010;
  localparam logic [3:0] c_COND_LT = 4'b1011;
  localparam logic [3:0] c_COND_GT = 4'b1100;
  localparam logic [3:0] c_COND_LE = 4'b1101;
  localparam logic [3:0] c_COND_AL = 4'b1110;

  localparam logic [1:0] c_SRCA_REG  = 2'd0;
  localparam logic [1:0] c_SRCA_PC   = 2'd1;
  localparam logic [1:0] c_SRCB_REG  = 2'd0;
  localparam logic [1:0] c_SRCB_IMM  = 2'd1;
  localparam logic [1:0] c_SRCB_FOUR = 2'd2;
  localparam logic [1:0] c_RES_ALU   = 2'd0;
  localparam logic [1:0] c_RES_MEM   = 2'd1;
  localparam logic [1:0] c_RES_PC    = 2'd2;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic       link_sel;
    logic       undef;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [2:0] alu_ctrl;
  } ctrl_out_t;

  function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      c_CMD_ADD: alu_decode = c_ALU_ADD;
      c_CMD_SUB: alu_decode = c_ALU_SUB;
      c_CMD_AND: alu_decode = c_ALU_AND;
      c_CMD_ORR: alu_decode = c_ALU_ORR;
      c_CMD_EOR: alu_decode = c_ALU_EOR;
      c_CMD_MOV: alu_decode = c_ALU_MOV;
      c_CMD_CMP: alu_decode = c_ALU_SUB;
      default:   alu_decode = c_ALU_ADD;
    endcase
  endfunction

  // Moore decode: depends only on a state and the latched instruction fields.
  function automatic ctrl_out_t state_outputs(input state_t s, input logic [1:0] op,
                                              input logic [5:0] funct, input logic [3:0] rd);
    ctrl_out_t o;
    o = '0;
    if (s != FETCH) begin
      o.imm_src = op;
      o.reg_src = {(op == 2'b01) && !funct[0], op == 2'b10};
    end
    case (s)
      FETCH: begin
        o.ir_write  = 1'b1;
        o.pc_write  = 1'b1;
        o.alu_src_a = c_SRCA_PC;
        o.alu_src_b = c_SRCB_FOUR;
      end
      DECODE: begin
        o.alu_src_a = c_SRCA_PC;
        o.alu_src_b = c_SRCB_FOUR;
      end
      MEMADR: o.alu_src_b = c_SRCB_IMM;
      MEMRD:  o.adr_src = 1'b1;
      MEMWB: begin
        o.reg_write  = 1'b1;
        o.result_src = c_RES_MEM;
      end
      MEMWR: begin
        o.mem_write = 1'b1;
        o.adr_src   = 1'b1;
      end
      EXECR: o.alu_ctrl = alu_decode(funct[4:1]);
      EXECI: begin
        o.alu_src_b = c_SRCB_IMM;
        o.alu_ctrl  = alu_decode(funct[4:1]);
      end
      ALUWB: begin
        o.reg_write = 1'b1;
        o.pc_write  = (rd == 4'd15);
      end
      LINK: begin
        o.reg_write  = 1'b1;
        o.link_sel   = 1'b1;
        o.result_src = c_RES_PC;
      end
      BRANCH: begin
        o.pc_write  = 1'b1;
        o.alu_src_b = c_SRCB_IMM;
      end
      UNDEF:   o.undef = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cond_check.sv
// -----------------------------------------------------------------------------
// cond_check : evaluates an instruction condition field against NZCV.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = flags_i;

  always_comb begin
    cond_ex_o = 1'b1;
    case (cond_i)
      c_COND_EQ: cond_ex_o = w_z;
      c_COND_NE: cond_ex_o = !w_z;
      c_COND_CS: cond_ex_o = w_c;
      c_COND_CC: cond_ex_o = !w_c;
      c_COND_MI: cond_ex_o = w_n;
      c_COND_PL: cond_ex_o = !w_n;
      c_COND_VS: cond_ex_o = w_v;
      c_COND_VC: cond_ex_o = !w_v;
      c_COND_HI: cond_ex_o = w_c && !w_z;
      c_COND_LS: cond_ex_o = !w_c || w_z;
      c_COND_GE: cond_ex_o = (w_n == w_v);
      c_COND_LT: cond_ex_o = (w_n != w_v);
      c_COND_GT: cond_ex_o = !w_z && (w_n == w_v);
      c_COND_LE: cond_ex_o = w_z || (w_n != w_v);
      default:   cond_ex_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl : multicycle ARM-subset control FSM with NZCV flags.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl #(
  parameter int ALU_CTRL_W = 3,
  parameter int LINK_REG   = 14,
  parameter int COND_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic [3:0]            Cond,
  input  logic [3:0]            ALUFlags,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  AdrSrc,
  output logic                  LinkSel,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [3:0]            Flags,
  output logic                  Undef
);
  import ctrl_pkg::*;

  if (ALU_CTRL_W < 3 || LINK_REG < 0 || LINK_REG > 14) begin : g_param_check
    $error("multicycle_ctrl: ALU_CTRL_W must be >= 3 and LINK_REG in 0..14");
  end

  state_t    state_q, state_d;
  logic      run_q;
  logic [1:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;
  logic [3:0] rd_q, rd_d;
  logic [3:0] cond_q, cond_d;
  logic [3:0] flags_q, flags_d;
  ctrl_out_t out_q, out_d;
  logic [3:0] w_cmd;
  logic      w_cond_raw;
  logic      w_cond_ex;

  cond_check u_cond_check (
    .cond_i    (cond_q),
    .flags_i   (flags_q),
    .cond_ex_o (w_cond_raw)
  );

  assign w_cond_ex = (COND_EN != 0) ? w_cond_raw : 1'b1;
  assign w_cmd     = funct_q[4:1];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    rd_d    = rd_q;
    cond_d  = cond_q;
    flags_d = flags_q;
    // First edge after reset release only enters FETCH so its enables are seen.
    if (!run_q) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          state_d = DECODE;
          op_d    = Op;
          funct_d = Funct;
          rd_d    = Rd;
          cond_d  = Cond;
        end
        DECODE: begin
          if (!w_cond_ex) begin
            state_d = FETCH;
          end else begin
            case (op_q)
              2'b01:   state_d = MEMADR;
              2'b00:   state_d = funct_q[5] ? EXECI : EXECR;
              2'b10:   state_d = funct_q[4] ? LINK : BRANCH;
              default: state_d = UNDEF;
            endcase
          end
        end
        MEMADR: state_d = funct_q[0] ? MEMRD : MEMWR;
        MEMRD:  state_d = MEMWB;
        LINK:   state_d = BRANCH;
        EXECR, EXECI: begin
          state_d = (w_cmd == c_CMD_CMP) ? FETCH : ALUWB;
          if (w_cmd == c_CMD_CMP) begin
            flags_d = ALUFlags;
          end else if (funct_q[0] && (w_cmd != c_CMD_MOV)) begin
            flags_d[3:2] = ALUFlags[3:2];
            if ((w_cmd == c_CMD_ADD) || (w_cmd == c_CMD_SUB)) begin
              flags_d[1:0] = ALUFlags[1:0];
            end
          end
        end
        default: state_d = FETCH;
      endcase
    end
    out_d = state_outputs(state_d, op_d, funct_d, rd_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
      op_q    <= '0;
      funct_q <= '0;
      rd_q    <= '0;
      cond_q  <= '0;
      flags_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      op_q    <= op_d;
      funct_q <= funct_d;
      rd_q    <= rd_d;
      cond_q  <= cond_d;
      flags_q <= flags_d;
      out_q   <= out_d;
    end
  end

  assign IRWrite    = out_q.ir_write;
  assign PCWrite    = out_q.pc_write;
  assign RegWrite   = out_q.reg_write;
  assign MemWrite   = out_q.mem_write;
  assign AdrSrc     = out_q.adr_src;
  assign LinkSel    = out_q.link_sel;
  assign Undef      = out_q.undef;
  assign ALUSrcA    = out_q.alu_src_a;
  assign ALUSrcB    = out_q.alu_src_b;
  assign ResultSrc  = out_q.result_src;
  assign ImmSrc     = out_q.imm_src;
  assign RegSrc     = out_q.reg_src;
  assign ALUControl = ALU_CTRL_W'(out_q.alu_ctrl);
  assign Flags      = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl : directed instruction sequences for multicycle_ctrl.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;

  logic       clk;
  logic       reset_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, LinkSel, Undef;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] Flags;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl #(
    .ALU_CTRL_W (3),
    .LINK_REG   (14),
    .COND_EN    (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .LinkSel    (LinkSel),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .Flags      (Flags),
    .Undef      (Undef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {IRWrite, PCWrite, RegWrite, MemWrite, Undef}
  function automatic logic [15:0] en();
    return {11'd0, IRWrite, PCWrite, RegWrite, MemWrite, Undef};
  endfunction

  function automatic logic [15:0] sel();
    return {1'b0, AdrSrc, LinkSel, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};
  endfunction

  // Called in a FETCH cycle; fields are latched on the next edge, then scrambled.
  task automatic issue(input string tag, input logic [3:0] c, input logic [1:0] op,
                       input logic [5:0] f, input logic [3:0] rd);
    chk({tag, "_fetch_en"}, en(), 16'b11000);
    Cond = c; Op = op; Funct = f; Rd = rd;
    tick();
    Cond = ~c; Op = 2'b11; Funct = ~f; Rd = ~rd;
  endtask

  initial begin
    reset_n = 1'b0; Op = '0; Funct = '0; Rd = '0; Cond = '0; ALUFlags = '0;
    tick();
    tick();
    chk("rst_en", en(), 16'd0);
    chk("rst_sel", sel(), 16'd0);
    chk("rst_flags", {12'd0, Flags}, 16'd0);
    reset_n = 1'b1;
    tick();
    chk("fetch_sel", {9'd0, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}, 16'b0110000);

    // ADD R1,R2,R3
    issue("add", 4'b1110, 2'b00, 6'b001000, 4'd1);
    chk("add_dec_en", en(), 16'd0);
    chk("add_dec_src", {12'd0, ImmSrc, RegSrc}, 16'b0000);
    tick();
    chk("add_exec_en", en(), 16'd0);
    chk("add_exec_alu", {11'd0, ALUSrcB, ALUControl}, 16'b00000);
    tick();
    chk("add_wb_en", en(), 16'b00100);
    tick();

    // SUBS with NZCV=0110
    issue("subs", 4'b1110, 2'b00, 6'b000101, 4'd1);
    tick();
    chk("subs_alu", {11'd0, ALUSrcB, ALUControl}, 16'b00001);
    ALUFlags = 4'b0110;
    tick();
    chk("subs_flags", {12'd0, Flags}, 16'b0110);
    chk("subs_wb_en", en(), 16'b00100);
    tick();

    // MOVS imm: flags untouched
    issue("movs", 4'b1110, 2'b00, 6'b111011, 4'd4);
    tick();
    chk("movs_alu", {11'd0, ALUSrcB, ALUControl}, 16'b01101);
    ALUFlags = 4'b1001;
    tick();
    chk("movs_flags", {12'd0, Flags}, 16'b0110);
    tick();

    // ANDS imm: NZ from ALU, CV kept
    issue("ands", 4'b1110, 2'b00, 6'b100001, 4'd5);
    tick();
    chk("ands_alu", {11'd0, ALUSrcB, ALUControl}, 16'b01010);
    ALUFlags = 4'b1011;
    tick();
    chk("ands_flags", {12'd0, Flags}, 16'b1010);
    chk("ands_wb_en", en(), 16'b00100);
    tick();

    // CMP: all four flags, no writeback
    issue("cmp", 4'b1110, 2'b00, 6'b010101, 4'd0);
    tick();
    chk("cmp_alu", {11'd0, ALUSrcB, ALUControl}, 16'b00001);
    ALUFlags = 4'b0100;
    tick();
    chk("cmp_flags", {12'd0, Flags}, 16'b0100);

    // EOR without S: flags unchanged
    issue("eor", 4'b1110, 2'b00, 6'b000010, 4'd6);
    tick();
    chk("eor_alu", {11'd0, ALUSrcB, ALUControl}, 16'b00100);
    ALUFlags = 4'b1111;
    tick();
    chk("eor_flags", {12'd0, Flags}, 16'b0100);
    chk("eor_wb_en", en(), 16'b00100);
    tick();

    // STRNE with Z=1: skipped
    issue("strne", 4'b0001, 2'b01, 6'b011000, 4'd2);
    chk("strne_dec_en", en(), 16'd0);
    tick();

    // STREQ with Z=1: executes
    issue("streq", 4'b0000, 2'b01, 6'b011000, 4'd2);
    chk("streq_dec_src", {12'd0, ImmSrc, RegSrc}, 16'b0110);
    tick();
    chk("streq_adr_en", en(), 16'd0);
    chk("streq_adr_src", {12'd0, ALUSrcA, ALUSrcB}, 16'b0001);
    tick();
    chk("streq_wr_en", en(), 16'b00010);
    chk("streq_wr_adr", {15'd0, AdrSrc}, 16'd1);
    tick();

    // BL
    issue("bl", 4'b1110, 2'b10, 6'b010000, 4'd0);
    chk("bl_dec_src", {12'd0, ImmSrc, RegSrc}, 16'b1001);
    tick();
    chk("bl_link_en", en(), 16'b00100);
    chk("bl_link_sel", {13'd0, LinkSel, ResultSrc}, 16'b110);
    tick();
    chk("bl_branch_en", en(), 16'b01000);
    chk("bl_branch_srcb", {14'd0, ALUSrcB}, 16'b01);
    tick();

    // LDR
    issue("ldr", 4'b1110, 2'b01, 6'b011001, 4'd3);
    tick();
    chk("ldr_adr_en", en(), 16'd0);
    tick();
    chk("ldr_rd_en", en(), 16'd0);
    chk("ldr_rd_adr", {15'd0, AdrSrc}, 16'd1);
    tick();
    chk("ldr_wb_en", en(), 16'b00100);
    chk("ldr_wb_res", {14'd0, ResultSrc}, 16'b01);
    tick();

    // Op=11: single Undef pulse
    issue("undef", 4'b1110, 2'b11, 6'b000000, 4'd0);
    chk("undef_dec_en", en(), 16'd0);
    tick();
    chk("undef_pulse", en(), 16'b00001);
    tick();

    // ADD to R15: RegWrite and PCWrite together
    issue("addpc", 4'b1110, 2'b00, 6'b001000, 4'd15);
    tick();
    tick();
    chk("addpc_wb_en", en(), 16'b01100);
    tick();

    // Reset asserted during MEMWR
    issue("strrst", 4'b1110, 2'b01, 6'b011000, 4'd2);
    tick();
    tick();
    chk("strrst_wr_en", en(), 16'b00010);
    #2;
    reset_n = 1'b0;
    #1;
    chk("strrst_mem", {15'd0, MemWrite}, 16'd0);
    chk("strrst_en", en(), 16'd0);
    chk("strrst_flags", {12'd0, Flags}, 16'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("strrst_fetch_en", en(), 16'b11000);
    chk("strrst_fetch_flags", {12'd0, Flags}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
